// File: rtl/writeback_regfile.sv
// Writeback stage and architectural register file.
// Selects the writeback value, applies the conditional-move gate, commits into
// a 2**ADDR_WIDTH-entry register file, serves two combinational read ports with
// same-cycle write-through bypass, and keeps a registered trace of the last commit.
module writeback_regfile #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   WB_RegWrite,
  input  logic                   WB_CondMov,
  input  logic                   WB_ZeroFlag,
  input  logic                   WB_MemtoReg,
  input  logic [DATA_WIDTH-1:0]  WB_ALUResult,
  input  logic [DATA_WIDTH-1:0]  WB_MemData,
  input  logic [ADDR_WIDTH-1:0]  WB_WriteRegister,
  input  logic [ADDR_WIDTH-1:0]  ReadRegister1,
  input  logic [ADDR_WIDTH-1:0]  ReadRegister2,
  output logic [DATA_WIDTH-1:0]  ReadData1,
  output logic [DATA_WIDTH-1:0]  ReadData2,
  output logic                   WriteValid,
  output logic [ADDR_WIDTH-1:0]  LastWriteRegister,
  output logic [DATA_WIDTH-1:0]  LastWriteData,
  output logic [COUNT_WIDTH-1:0] WriteCount
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DATA_WIDTH-1:0] write_data;
  logic                  commit;

  // Writeback value select and commit qualification; reset masks the bypass too
  always_comb begin
    write_data = WB_MemtoReg ? WB_MemData : WB_ALUResult;
    commit     = ~Rst & WB_RegWrite & (~WB_CondMov | WB_ZeroFlag)
               & (WB_WriteRegister != ADDR_WIDTH'(0));
  end

  // Register array update; entry 0 is never written and stays zero
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[WB_WriteRegister] <= write_data;
    end
  end

  // Registered writeback trace: pulse, last index/data, wrapping commit count
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      WriteValid        <= 1'b0;
      LastWriteRegister <= '0;
      LastWriteData     <= '0;
      WriteCount        <= '0;
    end else begin
      WriteValid <= commit;
      if (commit) begin
        LastWriteRegister <= WB_WriteRegister;
        LastWriteData     <= write_data;
        WriteCount        <= WriteCount + COUNT_WIDTH'(1);
      end
    end
  end

  // Read port 1: zero register, then write-through bypass, then array
  always_comb begin
    if (ReadRegister1 == ADDR_WIDTH'(0)) begin
      ReadData1 = '0;
    end else if (commit && (ReadRegister1 == WB_WriteRegister)) begin
      ReadData1 = write_data;
    end else begin
      ReadData1 = regs[ReadRegister1];
    end
  end

  // Read port 2: same priority as port 1, evaluated independently
  always_comb begin
    if (ReadRegister2 == ADDR_WIDTH'(0)) begin
      ReadData2 = '0;
    end else if (commit && (ReadRegister2 == WB_WriteRegister)) begin
      ReadData2 = write_data;
    end else begin
      ReadData2 = regs[ReadRegister2];
    end
  end

endmodule
